// File: rtl/rwc_puf_gen_pkg.sv
// Shared types and constants for the read-write collision PUF generator.
package rwc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WAIT  = 3'd2,
    CLEAR = 3'd3,
    RESP  = 3'd4
  } rwc_state_e;

  // Word written back after each collision so the next repetition starts clean.
  localparam logic [31:0] RWC_CLEAR_DEFAULT = '0;

  // Repetition counter width; covers SAMPLES up to 255.
  localparam int unsigned REP_W = 8;

endpackage

// File: rtl/rwc_puf_gen_wea_pulse.sv
// Half-cycle write-enable generator: a posedge/negedge toggle pair turns a
// one-cycle fire strobe into a pulse that is high from posedge to negedge.
module rwc_wea_pulse
  import rwc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  output logic we
);

  logic we_pos;
  logic we_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    we_pos <= 1'b0;
    else if (fire) we_pos <= ~we_pos;
  end

  // Following we_pos on the falling edge closes the pulse after half a cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) we_neg <= 1'b0;
    else        we_neg <= we_pos;
  end

  assign we = we_pos ^ we_neg;

endmodule

// File: rtl/rwc_puf_gen.sv
// Burst read-write collision PUF: per address, SAMPLES write/read collisions
// on an external dual-port BRAM, one response beat with pos/neg samples and flip mask.
module rwc_puf_gen
  import rwc_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       LEN_W       = 4,
  parameter int unsigned       SAMPLES     = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(RWC_CLEAR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cha_valid,
  output logic              cha_ready,
  input  logic [DATA_W-1:0] cha_data,
  input  logic [ADDR_W-1:0] cha_addr,
  input  logic [LEN_W-1:0]  cha_len,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_doutb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_pos,
  output logic [DATA_W-1:0] rsp_neg,
  output logic [DATA_W-1:0] rsp_flip,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  rwc_state_e state, next;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] pos_smp;
  logic [DATA_W-1:0] neg_smp;
  logic [DATA_W-1:0] first_smp;
  logic [DATA_W-1:0] flip_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              accept;
  logic              rsp_hs;
  logic              last_rep;
  logic              last_beat;
  logic              fire;

  assign cha_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cha_valid && cha_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign last_rep  = (rep_cnt == REP_W'(SAMPLES - 1));
  assign last_beat = (beat_cnt == len_q);

  // Pulses launch on the edge that enters WRITE or CLEAR, so fire is decoded
  // from the transition rather than the current state.
  always_comb begin
    next = state;
    fire = 1'b0;
    case (state)
      IDLE:    if (accept) next = WRITE;
      WRITE:   next = WAIT;
      WAIT:    next = CLEAR;
      CLEAR:   next = last_rep ? RESP : WRITE;
      RESP:    if (rsp_hs) next = last_beat ? IDLE : WRITE;
      default: next = IDLE;
    endcase
    if ((next == WRITE || next == CLEAR) && next != state) fire = 1'b1;
  end

  rwc_wea_pulse u_wea (
    .clk   (clk),
    .rst_n (rst_n),
    .fire  (fire),
    .we    (mem_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      pos_smp   <= '0;
      first_smp <= '0;
      flip_q    <= '0;
      rep_cnt   <= '0;
      beat_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_pos   <= '0;
      rsp_neg   <= '0;
      rsp_flip  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (accept) begin
          data_q   <= cha_data;
          mem_din  <= cha_data;
          mem_addr <= cha_addr;
          len_q    <= cha_len;
          rep_cnt  <= '0;
          flip_q   <= '0;
          beat_cnt <= '0;
        end
        WRITE: begin
          pos_smp <= mem_doutb;
          if (rep_cnt == '0) first_smp <= mem_doutb;
          else               flip_q    <= flip_q | (mem_doutb ^ first_smp);
        end
        WAIT: mem_din <= CLEAR_VALUE;
        CLEAR: if (!last_rep) begin
          rep_cnt <= rep_cnt + 1'b1;
          mem_din <= data_q;
        end
        // Beat registers load one cycle after entering RESP and hold until taken.
        RESP: begin
          if (rsp_hs) begin
            rsp_valid <= 1'b0;
            if (!last_beat) begin
              mem_addr <= mem_addr + 1'b1;
              beat_cnt <= beat_cnt + 1'b1;
              rep_cnt  <= '0;
              flip_q   <= '0;
              mem_din  <= data_q;
            end
          end else if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_pos   <= pos_smp;
            rsp_neg   <= neg_smp;
            rsp_flip  <= flip_q;
            rsp_addr  <= mem_addr;
            rsp_last  <= last_beat;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)              neg_smp <= '0;
    else if (state == WRITE) neg_smp <= mem_doutb;
  end

endmodule
